// File: rtl/xor_checksum_checker_pkg.sv
// Shared types and defaults for the XOR word checksum checker.
package xor_checksum_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } chk_state_t;

    localparam int DEF_WIDTH     = 24;
    localparam int DEF_MAX_WORDS = 16;
    localparam int DEF_CNT_W     = 5;

endpackage

// File: rtl/xor_checksum_checker_xor_word.sv
// Word-wide XOR built from per-bit gates; feeds both accumulate and compare.
module xor_word
    import xor_checksum_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign y[i] = a[i] ^ b[i];
    end

endmodule

// File: rtl/xor_checksum_checker.sv
// Receive-side XOR checksum checker: accumulates payload words, compares with the
// trailing checksum word and reports pass / fail / overlength.
//
// state     | meaning
// ST_IDLE   | waiting for first word of a frame, verdict flags held
// ST_ACC    | accumulating payload words
// ST_DRAIN  | overlength seen, discarding words until the checksum word
// ST_RESULT | verdict valid (Done), not ready for one cycle
module xor_checksum_checker
    import xor_checksum_checker_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_WORDS = DEF_MAX_WORDS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    input  logic             InLast,
    output logic             Busy,
    output logic             Done,
    output logic             ChkOk,
    output logic             ChkErr,
    output logic             LenErr,
    output logic [CNT_W-1:0] WordCount,
    output logic [WIDTH-1:0] CalcSum
);

    chk_state_t       state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             len_q, len_d;
    logic [WIDTH-1:0] xor_out;
    logic             in_xfer;

    xor_word #(.WIDTH(WIDTH)) u_xor (
        .a (sum_q),
        .b (InData),
        .y (xor_out)
    );

    assign in_xfer = InValid && InReady;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        ok_d    = ok_q;
        err_d   = err_q;
        len_d   = len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_xfer) begin
                    ok_d  = 1'b0;
                    err_d = 1'b0;
                    len_d = 1'b0;
                    if (!InLast) begin
                        sum_d   = InData;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_ACC;
                    end else begin
                        // Empty payload: the checksum must itself be zero.
                        sum_d   = '0;
                        cnt_d   = '0;
                        ok_d    = (InData == '0);
                        err_d   = (InData != '0);
                        state_d = ST_RESULT;
                    end
                end
            end
            ST_ACC: begin
                if (in_xfer) begin
                    if (InLast) begin
                        ok_d    = (xor_out == '0);
                        err_d   = (xor_out != '0);
                        state_d = ST_RESULT;
                    end else if (cnt_q == CNT_W'(MAX_WORDS)) begin
                        len_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        sum_d = xor_out;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (in_xfer && InLast) begin
                    ok_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            sum_q   <= '0;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            len_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            len_q   <= len_d;
        end
    end

    assign InReady   = (state_q != ST_RESULT);
    assign Busy      = (state_q != ST_IDLE);
    assign Done      = (state_q == ST_RESULT);
    assign ChkOk     = ok_q;
    assign ChkErr    = err_q;
    assign LenErr    = len_q;
    assign WordCount = cnt_q;
    assign CalcSum   = sum_q;

endmodule

// File: tb/tb_xor_checksum_checker.sv
// Scoreboard bench: driver pushes the reference verdict per frame, monitor checks on Done.
module tb_xor_checksum_checker;

    localparam int WIDTH     = 24;
    localparam int MAX_WORDS = 16;
    localparam int CNT_W     = 5;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] InData;
    logic             InLast;
    logic             Busy, Done, ChkOk, ChkErr, LenErr;
    logic [CNT_W-1:0] WordCount;
    logic [WIDTH-1:0] CalcSum;

    xor_checksum_checker #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .InValid   (InValid),
        .InReady   (InReady),
        .InData    (InData),
        .InLast    (InLast),
        .Busy      (Busy),
        .Done      (Done),
        .ChkOk     (ChkOk),
        .ChkErr    (ChkErr),
        .LenErr    (LenErr),
        .WordCount (WordCount),
        .CalcSum   (CalcSum)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic             ok;
        logic             err;
        logic             len;
        logic [CNT_W-1:0] cnt;
        logic [WIDTH-1:0] sum;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             last_exp;
    logic             have_last = 1'b0;
    logic [WIDTH-1:0] pay_q[$];
    int               n_cmp  = 0;
    int               n_fail = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: XOR of at most MAX_WORDS payload words; longer frames are overlength.
    function automatic exp_t model(input logic [WIDTH-1:0] chk);
        exp_t e;
        logic [WIDTH-1:0] s;
        int n;
        s = '0;
        n = pay_q.size();
        for (int i = 0; i < n && i < MAX_WORDS; i++) s = s ^ pay_q[i];
        e.sum = s;
        if (n > MAX_WORDS) begin
            e.len = 1'b1; e.ok = 1'b0; e.err = 1'b1;
            e.cnt = CNT_W'(MAX_WORDS);
        end else begin
            e.len = 1'b0;
            e.ok  = (s == chk);
            e.err = (s != chk);
            e.cnt = CNT_W'(n);
        end
        return e;
    endfunction

    always @(negedge Clock) begin
        if (!Reset) begin
            if (Done) begin
                if (sb_q.size() == 0) begin
                    cmp("unexpected_done", 32'(Done), 32'(0));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    cmp("chk_ok",     32'(ChkOk),     32'(e.ok));
                    cmp("chk_err",    32'(ChkErr),    32'(e.err));
                    cmp("len_err",    32'(LenErr),    32'(e.len));
                    cmp("word_count", 32'(WordCount), 32'(e.cnt));
                    cmp("calc_sum",   32'(CalcSum),   32'(e.sum));
                    cmp("ready_in_result", 32'(InReady), 32'(0));
                    last_exp  = e;
                    have_last = 1'b1;
                end
            end else if (!Busy && have_last) begin
                cmp("hold_ok",    32'(ChkOk),     32'(last_exp.ok));
                cmp("hold_err",   32'(ChkErr),    32'(last_exp.err));
                cmp("hold_len",   32'(LenErr),    32'(last_exp.len));
                cmp("hold_count", 32'(WordCount), 32'(last_exp.cnt));
                cmp("hold_sum",   32'(CalcSum),   32'(last_exp.sum));
                cmp("ready_idle", 32'(InReady),   32'(1));
            end
        end
    end

    // Starts and ends on a falling edge; leaves InValid asserted for back-to-back words.
    task automatic drive_word(input logic [WIDTH-1:0] d, input logic last, input logic [WIDTH-1:0] chk);
        int wait_cnt;
        InValid  = 1'b1;
        InData   = d;
        InLast   = last;
        wait_cnt = 0;
        while (!InReady && wait_cnt < 50) begin
            @(negedge Clock);
            wait_cnt++;
        end
        if (!InReady) cmp("ready_timeout", 32'(InReady), 32'(1));
        if (last) sb_q.push_back(model(chk));
        @(negedge Clock);
    endtask

    task automatic idle_gap(input int gap);
        InValid = 1'b0;
        InData  = WIDTH'($urandom);
        InLast  = 1'($urandom);
        repeat (gap) @(negedge Clock);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] chk, input int gap_max, input logic fixed_gap);
        foreach (pay_q[i]) begin
            idle_gap(fixed_gap ? gap_max : int'($urandom_range(gap_max, 0)));
            drive_word(pay_q[i], 1'b0, chk);
        end
        idle_gap(fixed_gap ? gap_max : int'($urandom_range(gap_max, 0)));
        drive_word(chk, 1'b1, chk);
        InValid = 1'b0;
    endtask

    task automatic do_reset();
        have_last = 1'b0;
        InValid   = 1'b0;
        Reset     = 1'b1;
        @(negedge Clock);
        cmp("rst_ready", 32'(InReady),   32'(1));
        cmp("rst_busy",  32'(Busy),      32'(0));
        cmp("rst_done",  32'(Done),      32'(0));
        cmp("rst_ok",    32'(ChkOk),     32'(0));
        cmp("rst_err",   32'(ChkErr),    32'(0));
        cmp("rst_len",   32'(LenErr),    32'(0));
        cmp("rst_count", 32'(WordCount), 32'(0));
        cmp("rst_sum",   32'(CalcSum),   32'(0));
        Reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] s;
        int n;
        Reset   = 1'b1;
        InValid = 1'b0;
        InData  = '0;
        InLast  = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        do_reset();

        pay_q = '{24'h123456, 24'h00FF00};
        send_frame(24'h12CB56, 0, 1'b0);
        send_frame(24'h12CB57, 0, 1'b0);
        pay_q = {};
        send_frame(24'h000000, 0, 1'b0);
        send_frame(24'h000001, 0, 1'b0);

        pay_q = {};
        for (int i = 0; i < MAX_WORDS + 1; i++) pay_q.push_back(WIDTH'($urandom));
        send_frame(WIDTH'($urandom), 0, 1'b0);

        pay_q = '{24'hABCDEF, 24'h010203, 24'h777777};
        s = 24'hABCDEF ^ 24'h010203 ^ 24'h777777;
        send_frame(s, 3, 1'b1);

        // Abandon a frame with reset after two words; no verdict must appear.
        drive_word(24'h111111, 1'b0, '0);
        drive_word(24'h222222, 1'b0, '0);
        do_reset();
        repeat (3) @(negedge Clock);
        cmp("no_done_after_rst", 32'(Done), 32'(0));
        pay_q = '{24'h123456, 24'h00FF00};
        send_frame(24'h12CB56, 1, 1'b0);

        for (int f = 0; f < 40; f++) begin
            n = (f % 8 == 0) ? int'($urandom_range(MAX_WORDS + 4, MAX_WORDS)) : int'($urandom_range(MAX_WORDS, 0));
            pay_q = {};
            s = '0;
            for (int i = 0; i < n; i++) begin
                pay_q.push_back(WIDTH'($urandom));
                if (i < MAX_WORDS) s = s ^ pay_q[i];
            end
            if ($urandom_range(1, 0) == 1) s = WIDTH'($urandom);
            send_frame(s, (f % 3 == 0) ? 2 : 0, 1'b0);
        end

        repeat (5) @(negedge Clock);
        cmp("scoreboard_empty", 32'(sb_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
